// File: rtl/lsu_mem_arbiter_if.sv
// Bundle of the LSU-array side and the data-memory side of the arbiter.
//
// Handshake semantics (both sides):
//   A requester raises *_valid together with its address/data and holds them
//   stable until the matching *_ready is seen high. The responder raises
//   *_ready when the access is done. On the LSU side the ready stays high until
//   the LSU drops its valid. On the memory side the ready is sampled only while
//   the arbiter waits for that access. A ready seen outside that window has no
//   effect.
//
// modport master : the arbiter (drives memory requests and LSU acknowledges)
// modport slave  : the environment (LSU array plus memory)
interface lsu_mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
);
    // LSU array side
    logic [NUM_CONSUMERS-1:0]                lsu_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] lsu_read_address;
    logic [NUM_CONSUMERS-1:0]                lsu_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] lsu_read_data;
    logic [NUM_CONSUMERS-1:0]                lsu_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] lsu_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] lsu_write_data;
    logic [NUM_CONSUMERS-1:0]                lsu_write_ready;

    // Data-memory side
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        input  lsu_read_valid,
        input  lsu_read_address,
        output lsu_read_ready,
        output lsu_read_data,
        input  lsu_write_valid,
        input  lsu_write_address,
        input  lsu_write_data,
        output lsu_write_ready,
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output mem_write_valid,
        output mem_write_address,
        output mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        output lsu_read_valid,
        output lsu_read_address,
        input  lsu_read_ready,
        input  lsu_read_data,
        output lsu_write_valid,
        output lsu_write_address,
        output lsu_write_data,
        input  lsu_write_ready,
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  mem_write_valid,
        input  mem_write_address,
        input  mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel between the per-thread
// LSUs of a core. One access is in flight at a time; the grant is held until
// memory completes and the granted LSU drops its request. All outputs are
// registered; the FSM state and round-robin pointer are exposed for debug.
module lsu_mem_arbiter #(
    parameter  int NUM_CONSUMERS = 4,
    parameter  int ADDR_BITS     = 8,
    parameter  int DATA_BITS     = 8,
    localparam int ID_W          = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    lsu_mem_arbiter_if.master bus,
    output logic            busy,
    output logic [2:0]      state_dbg,
    output logic [ID_W-1:0] rr_ptr_dbg,
    output logic [ID_W-1:0] grant_id_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_READ_WAIT   = 3'd1,
        ST_WRITE_WAIT  = 3'd2,
        ST_READ_RELAY  = 3'd3,
        ST_WRITE_RELAY = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] grant_next;

    logic                 mem_read_valid_q,    mem_read_valid_d;
    logic [ADDR_BITS-1:0] mem_read_address_q,  mem_read_address_d;
    logic                 mem_write_valid_q,   mem_write_valid_d;
    logic [ADDR_BITS-1:0] mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0] mem_write_data_q,    mem_write_data_d;

    logic [NUM_CONSUMERS-1:0]                lsu_read_ready_q,  lsu_read_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] lsu_read_data_q,   lsu_read_data_d;
    logic [NUM_CONSUMERS-1:0]                lsu_write_ready_q, lsu_write_ready_d;

    logic busy_q, busy_d;

    // Round-robin scan results
    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic            pick_is_read;
    logic [ID_W-1:0] cand;
    int              idx;

    // Pointer to the consumer after the current grant, wrapping at NUM_CONSUMERS
    assign grant_next = (grant_id_q == ID_W'(NUM_CONSUMERS - 1)) ? '0 : grant_id_q + 1'b1;

    // Find the first requesting consumer starting at rr_ptr; a pending read beats a write
    always_comb begin
        pick_found   = 1'b0;
        pick_id      = '0;
        pick_is_read = 1'b0;
        cand         = '0;
        idx          = 0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CONSUMERS) begin
                idx = idx - NUM_CONSUMERS;
            end
            cand = ID_W'(idx);
            if (!pick_found && (bus.lsu_read_valid[cand] || bus.lsu_write_valid[cand])) begin
                pick_found   = 1'b1;
                pick_id      = cand;
                pick_is_read = bus.lsu_read_valid[cand];
            end
        end
    end

    // Next-state and next-output logic; every registered value holds by default
    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_id_d          = grant_id_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        lsu_read_ready_d    = lsu_read_ready_q;
        lsu_read_data_d     = lsu_read_data_q;
        lsu_write_ready_d   = lsu_write_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_id;
                    if (pick_is_read) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = bus.lsu_read_address[pick_id];
                        state_d            = ST_READ_WAIT;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = bus.lsu_write_address[pick_id];
                        mem_write_data_d    = bus.lsu_write_data[pick_id];
                        state_d             = ST_WRITE_WAIT;
                    end
                end
            end

            ST_READ_WAIT: begin
                if (bus.mem_read_ready) begin
                    mem_read_valid_d            = 1'b0;
                    lsu_read_data_d[grant_id_q]  = bus.mem_read_data;
                    lsu_read_ready_d[grant_id_q] = 1'b1;
                    state_d                     = ST_READ_RELAY;
                end
            end

            ST_WRITE_WAIT: begin
                if (bus.mem_write_ready) begin
                    mem_write_valid_d             = 1'b0;
                    lsu_write_ready_d[grant_id_q] = 1'b1;
                    state_d                       = ST_WRITE_RELAY;
                end
            end

            ST_READ_RELAY: begin
                if (!bus.lsu_read_valid[grant_id_q]) begin
                    lsu_read_ready_d[grant_id_q] = 1'b0;
                    rr_ptr_d                     = grant_next;
                    state_d                      = ST_IDLE;
                end
            end

            ST_WRITE_RELAY: begin
                if (!bus.lsu_write_valid[grant_id_q]) begin
                    lsu_write_ready_d[grant_id_q] = 1'b0;
                    rr_ptr_d                      = grant_next;
                    state_d                       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears everything without waiting for clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            rr_ptr_q            <= '0;
            grant_id_q          <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            lsu_read_ready_q    <= '0;
            lsu_read_data_q     <= '0;
            lsu_write_ready_q   <= '0;
            busy_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_id_q          <= grant_id_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            lsu_read_ready_q    <= lsu_read_ready_d;
            lsu_read_data_q     <= lsu_read_data_d;
            lsu_write_ready_q   <= lsu_write_ready_d;
            busy_q              <= busy_d;
        end
    end

    assign bus.mem_read_valid    = mem_read_valid_q;
    assign bus.mem_read_address  = mem_read_address_q;
    assign bus.mem_write_valid   = mem_write_valid_q;
    assign bus.mem_write_address = mem_write_address_q;
    assign bus.mem_write_data    = mem_write_data_q;
    assign bus.lsu_read_ready    = lsu_read_ready_q;
    assign bus.lsu_read_data     = lsu_read_data_q;
    assign bus.lsu_write_ready   = lsu_write_ready_q;

    assign busy         = busy_q;
    assign state_dbg    = state_q;
    assign rr_ptr_dbg   = rr_ptr_q;
    assign grant_id_dbg = grant_id_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: LSU driver tasks, a latency-programmable
// memory responder, and a monitor that pops expected transactions from a queue.
`timescale 1ns/1ps
module tb_lsu_mem_arbiter;

    localparam int N   = 4;
    localparam int EW  = 20;
    localparam int TMO = 100;

    localparam logic [1:0] K_MRD = 2'd0;
    localparam logic [1:0] K_MWR = 2'd1;
    localparam logic [1:0] K_LRD = 2'd2;
    localparam logic [1:0] K_LWR = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RW   = 3'd1;
    localparam logic [2:0] S_WW   = 3'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       busy;
    logic [2:0] state_dbg;
    logic [1:0] rr_ptr_dbg;
    logic [1:0] grant_id_dbg;

    lsu_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) bus ();

    lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master),
        .busy         (busy),
        .state_dbg    (state_dbg),
        .rr_ptr_dbg   (rr_ptr_dbg),
        .grant_id_dbg (grant_id_dbg)
    );

    // ---------------- LSU / memory stimulus signals ----------------
    logic [N-1:0]        rd_v = '0;
    logic [N-1:0][7:0]   rd_a = '0;
    logic [N-1:0]        wr_v = '0;
    logic [N-1:0][7:0]   wr_a = '0;
    logic [N-1:0][7:0]   wr_d = '0;
    logic                rd_rdy = 1'b0;
    logic                wr_rdy = 1'b0;
    logic                stray  = 1'b0;
    logic [7:0]          rd_dat = '0;
    logic [7:0]          mem_img [256];
    int                  rd_lat = 3;
    int                  wr_lat = 2;
    int                  rd_cnt = 0;
    int                  wr_cnt = 0;

    assign bus.lsu_read_valid    = rd_v;
    assign bus.lsu_read_address  = rd_a;
    assign bus.lsu_write_valid   = wr_v;
    assign bus.lsu_write_address = wr_a;
    assign bus.lsu_write_data    = wr_d;
    assign bus.mem_read_ready    = rd_rdy;
    assign bus.mem_read_data     = rd_dat;
    assign bus.mem_write_ready   = wr_rdy | stray;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [EW-1:0] ev(input logic [1:0] k, input logic [1:0] id,
                                         input logic [7:0] a, input logic [7:0] d);
        return {k, id, a, d};
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void sb_check(input string name, input logic [EW-1:0] obs);
        logic [EW-1:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event 0x%0h, expected none", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                n_fail++;
                $display("FAIL %s: got event 0x%0h, expected 0x%0h", name, obs, e);
            end
        end
    endfunction

    // ---------------- monitor: one event per rising valid/ready ----------------
    logic         p_mrv = 1'b0;
    logic         p_mwv = 1'b0;
    logic [N-1:0] p_lrr = '0;
    logic [N-1:0] p_lwr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_read_valid && !p_mrv)
                sb_check("mem_rd", ev(K_MRD, 2'd0, bus.mem_read_address, 8'h00));
            if (bus.mem_write_valid && !p_mwv)
                sb_check("mem_wr", ev(K_MWR, 2'd0, bus.mem_write_address, bus.mem_write_data));
            for (int i = 0; i < N; i++) begin
                if (bus.lsu_read_ready[i] && !p_lrr[i])
                    sb_check("lsu_rd", ev(K_LRD, 2'(i), 8'h00, bus.lsu_read_data[i]));
                if (bus.lsu_write_ready[i] && !p_lwr[i])
                    sb_check("lsu_wr", ev(K_LWR, 2'(i), 8'h00, 8'h00));
            end
            p_mrv = bus.mem_read_valid;
            p_mwv = bus.mem_write_valid;
            p_lrr = bus.lsu_read_ready;
            p_lwr = bus.lsu_write_ready;
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rd_rdy) begin
                rd_rdy = 1'b0;
            end else if (bus.mem_read_valid) begin
                if (rd_cnt == rd_lat) begin
                    rd_rdy = 1'b1;
                    rd_dat = mem_img[bus.mem_read_address];
                    rd_cnt = 0;
                end else begin
                    rd_cnt++;
                end
            end else begin
                rd_cnt = 0;
            end
            if (wr_rdy) begin
                wr_rdy = 1'b0;
            end else if (bus.mem_write_valid) begin
                if (wr_cnt == wr_lat) begin
                    wr_rdy = 1'b1;
                    mem_img[bus.mem_write_address] = bus.mem_write_data;
                    wr_cnt = 0;
                end else begin
                    wr_cnt++;
                end
            end else begin
                wr_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic lsu_read(input logic [1:0] id, input logic [7:0] addr, input int hold);
        int cnt;
        rd_a[id] = addr;
        rd_v[id] = 1'b1;
        cnt = 0;
        while (!bus.lsu_read_ready[id] && cnt < TMO) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.lsu_read_ready[id]) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_timeout: lsu %0d got no read ready, expected one within %0d cycles", id, TMO);
            rd_v[id] = 1'b0;
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("rd_ready_held", 32'(bus.lsu_read_ready[id]), 32'd1);
            end
            rd_v[id] = 1'b0;
            @(negedge clk);
            check("rd_ready_released", 32'(bus.lsu_read_ready[id]), 32'd0);
            check("rr_after_rd", 32'(rr_ptr_dbg), 32'(2'(id + 2'd1)));
        end
    endtask

    task automatic lsu_write(input logic [1:0] id, input logic [7:0] addr, input logic [7:0] data);
        int cnt;
        wr_a[id] = addr;
        wr_d[id] = data;
        wr_v[id] = 1'b1;
        cnt = 0;
        while (!bus.lsu_write_ready[id] && cnt < TMO) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.lsu_write_ready[id]) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_timeout: lsu %0d got no write ready, expected one within %0d cycles", id, TMO);
            wr_v[id] = 1'b0;
        end else begin
            wr_v[id] = 1'b0;
            @(negedge clk);
            check("wr_ready_released", 32'(bus.lsu_write_ready[id]), 32'd0);
            check("rr_after_wr", 32'(rr_ptr_dbg), 32'(2'(id + 2'd1)));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000ns, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test sequence ----------------
    initial begin : main
        int cnt;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'h00;
        mem_img[8'h10] = 8'hA5;
        mem_img[8'h11] = 8'h5A;
        mem_img[8'h30] = 8'hC3;
        mem_img[8'h31] = 8'h1E;
        mem_img[8'h32] = 8'hE1;
        mem_img[8'h33] = 8'h99;
        mem_img[8'h40] = 8'h11;
        mem_img[8'h41] = 8'h22;
        mem_img[8'h42] = 8'h33;
        mem_img[8'h43] = 8'h44;
        mem_img[8'h44] = 8'h4D;
        mem_img[8'h50] = 8'h77;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_rr", 32'(rr_ptr_dbg), 32'd0);
        check("rst_grant", 32'(grant_id_dbg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mrv", 32'(bus.mem_read_valid), 32'd0);
        check("rst_mwv", 32'(bus.mem_write_valid), 32'd0);
        check("rst_lrr", 32'(bus.lsu_read_ready), 32'd0);
        check("rst_lwr", 32'(bus.lsu_write_ready), 32'd0);
        check("rst_lrd", 32'(bus.lsu_read_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read: LSU2 addr 0x10 returns 0xA5, ready held 2 extra cycles
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h10, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd2, 8'h00, 8'hA5));
        fork
            lsu_read(2'd2, 8'h10, 2);
            begin
                @(negedge clk);
                check("rd_latency", 32'(bus.mem_read_valid), 32'd1);
                check("rd_addr", 32'(bus.mem_read_address), 32'h10);
                check("rd_busy", 32'(busy), 32'd1);
            end
        join

        // Read and write pending on LSU1: read first, then write 0x20/0x5C
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h11, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd1, 8'h00, 8'h5A));
        exp_q.push_back(ev(K_MWR, 2'd0, 8'h20, 8'h5C));
        exp_q.push_back(ev(K_LWR, 2'd1, 8'h00, 8'h00));
        fork
            lsu_read(2'd1, 8'h11, 0);
            lsu_write(2'd1, 8'h20, 8'h5C);
        join
        check("rd_data_kept", 32'(bus.lsu_read_data[2]), 32'hA5);

        // Wrap: bring rr_ptr to 3, then LSU1 and LSU3 request together
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h30, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd2, 8'h00, 8'hC3));
        lsu_read(2'd2, 8'h30, 0);
        check("wrap_rr_start", 32'(rr_ptr_dbg), 32'd3);
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h31, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd3, 8'h00, 8'h1E));
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h32, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd1, 8'h00, 8'hE1));
        fork
            lsu_read(2'd1, 8'h32, 0);
            lsu_read(2'd3, 8'h31, 0);
        join

        // Contention: rr_ptr back to 0 via LSU3, then all four read at once
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h33, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd3, 8'h00, 8'h99));
        lsu_read(2'd3, 8'h33, 0);
        check("cont_rr_start", 32'(rr_ptr_dbg), 32'd0);
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h40, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd0, 8'h00, 8'h11));
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h41, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd1, 8'h00, 8'h22));
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h42, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd2, 8'h00, 8'h33));
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h43, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd3, 8'h00, 8'h44));
        fork
            lsu_read(2'd0, 8'h40, 0);
            lsu_read(2'd1, 8'h41, 0);
            lsu_read(2'd2, 8'h42, 0);
            lsu_read(2'd3, 8'h43, 0);
        join

        // Stray mem_write_ready during READ_WAIT must be ignored
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h44, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd0, 8'h00, 8'h4D));
        fork
            lsu_read(2'd0, 8'h44, 0);
            begin
                cnt = 0;
                while (!bus.mem_read_valid && cnt < TMO) begin
                    @(negedge clk);
                    cnt++;
                end
                @(negedge clk);
                stray = 1'b1;
                @(negedge clk);
                stray = 1'b0;
                check("stray_state", 32'(state_dbg), 32'(S_RW));
                check("stray_mwv", 32'(bus.mem_write_valid), 32'd0);
                check("stray_lwr", 32'(bus.lsu_write_ready), 32'd0);
            end
        join

        // Protocol violation: LSU1 drops valid during READ_WAIT, ready pulses once
        exp_q.push_back(ev(K_MRD, 2'd0, 8'h50, 8'h00));
        exp_q.push_back(ev(K_LRD, 2'd1, 8'h00, 8'h77));
        rd_a[1] = 8'h50;
        rd_v[1] = 1'b1;
        @(negedge clk);
        check("viol_grant", 32'(state_dbg), 32'(S_RW));
        rd_v[1] = 1'b0;
        cnt = 0;
        while (!bus.lsu_read_ready[1] && cnt < TMO) begin
            @(negedge clk);
            cnt++;
        end
        check("viol_ready_seen", 32'(bus.lsu_read_ready[1]), 32'd1);
        @(negedge clk);
        check("viol_pulse", 32'(bus.lsu_read_ready[1]), 32'd0);
        check("viol_idle", 32'(state_dbg), 32'(S_IDLE));

        // Reset during WRITE_WAIT: outputs drop without a clock edge
        wr_lat = 8;
        exp_q.push_back(ev(K_MWR, 2'd0, 8'h60, 8'h3C));
        wr_a[3] = 8'h60;
        wr_d[3] = 8'h3C;
        wr_v[3] = 1'b1;
        cnt = 0;
        while (!bus.mem_write_valid && cnt < TMO) begin
            @(negedge clk);
            cnt++;
        end
        check("rstw_state", 32'(state_dbg), 32'(S_WW));
        check("rstw_rr_before", 32'(rr_ptr_dbg), 32'd2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstw_mwv", 32'(bus.mem_write_valid), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_lwr", 32'(bus.lsu_write_ready), 32'd0);
        wr_v[3] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstw_idle", 32'(state_dbg), 32'(S_IDLE));
        check("rstw_rr", 32'(rr_ptr_dbg), 32'd0);
        check("rstw_busy_after", 32'(busy), 32'd0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
